// File: rtl/temp_hum_pkg.sv
// -----------------------------------------------------------------------------
// temp_hum_pkg
//   Shared definitions for the temperature/humidity measurement controller:
//   the controller state encoding and the default parameter values used by
//   temp_hum_meas_ctrl and anything that instantiates it.
// -----------------------------------------------------------------------------
package temp_hum_pkg;

  // Default width of the measurement-period field, in bits (period in seconds).
  localparam int DEFAULT_PERIOD_W    = 8;

  // Default width of each raw temperature / humidity sample.
  localparam int DEFAULT_DATA_W      = 16;

  // Default number of whole seconds the sensor gets to answer a trigger.
  localparam int DEFAULT_TIMEOUT_SEC = 2;

  // Controller states.
  //   ST_IDLE        : disabled, 1 s timer held in clear
  //   ST_WAIT_PERIOD : counting seconds until the next trigger
  //   ST_TRIGGER     : single-cycle trigger pulse to the sensor interface
  //   ST_WAIT_DONE   : waiting for the sensor completion strobe or a timeout
  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WAIT_PERIOD = 2'd1,
    ST_TRIGGER     = 2'd2,
    ST_WAIT_DONE   = 2'd3
  } meas_state_t;

  // Saturate a zero timeout to one second so the counter compare below never
  // underflows.
  function automatic int eff_timeout(input int timeout_sec);
    return (timeout_sec < 1) ? 1 : timeout_sec;
  endfunction

endpackage : temp_hum_pkg

// File: rtl/temp_hum_meas_ctrl.sv
// -----------------------------------------------------------------------------
// temp_hum_meas_ctrl
//   Periodic measurement controller for a temperature/humidity sensor.
//   Every period_sec seconds (measured with an external 1 s timer counter) it
//   fires a one-cycle trigger, then waits for the sensor's completion strobe.
//   Captured samples are presented on temp_data/hum_data with a one-cycle
//   data_valid pulse; a sensor that does not answer within TIMEOUT_SEC seconds
//   raises the sticky timeout_err flag.
//
// Ports
//   pclk             in   clock, rising edge
//   preset           in   synchronous active-high reset
//   ctrl_en          in   level, 1 enables periodic measurement
//   period_sec       in   seconds between triggers (latched at latch points)
//   count_eq_1s      in   one-cycle tick from the external 1 s timer
//   temp_counter_en  out  enable for the external 1 s timer
//   temp_counter_clr out  synchronous clear for the external 1 s timer
//   meas_start       out  one-cycle trigger to the sensor interface
//   sensor_done      in   one-cycle completion strobe, samples valid with it
//   sensor_temp      in   raw temperature sample
//   sensor_hum       in   raw humidity sample
//   temp_data        out  last captured temperature
//   hum_data         out  last captured humidity
//   data_valid       out  one-cycle pulse, the cycle after a capture
//   timeout_err      out  sticky timeout flag
//   err_clr          in   one-cycle clear for timeout_err
//   busy             out  1 whenever the controller is not idle
//   meas_cnt         out  number of successful captures (wraps)
// -----------------------------------------------------------------------------
module temp_hum_meas_ctrl
  import temp_hum_pkg::*;
#(
  parameter int PERIOD_W    = DEFAULT_PERIOD_W,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int TIMEOUT_SEC = DEFAULT_TIMEOUT_SEC
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic                ctrl_en,
  input  logic [PERIOD_W-1:0] period_sec,
  input  logic                count_eq_1s,
  output logic                temp_counter_en,
  output logic                temp_counter_clr,
  output logic                meas_start,
  input  logic                sensor_done,
  input  logic [DATA_W-1:0]   sensor_temp,
  input  logic [DATA_W-1:0]   sensor_hum,
  output logic [DATA_W-1:0]   temp_data,
  output logic [DATA_W-1:0]   hum_data,
  output logic                data_valid,
  output logic                timeout_err,
  input  logic                err_clr,
  output logic                busy,
  output logic [15:0]         meas_cnt
);

  // The seconds counter serves both the period wait and the timeout wait, so
  // it must be wide enough for whichever limit is larger.
  localparam int TIMEOUT_EFF = eff_timeout(TIMEOUT_SEC);
  localparam int TO_BITS     = $clog2(TIMEOUT_EFF + 1);
  localparam int CNT_W       = (PERIOD_W > TO_BITS) ? PERIOD_W : TO_BITS;

  // sec_cnt value on which the final timeout tick lands.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_EFF - 1);

  meas_state_t          state;
  logic [CNT_W-1:0]     sec_cnt;
  logic [PERIOD_W-1:0]  period_q;

  logic [CNT_W-1:0]     period_last;
  logic                 period_hit;
  logic                 timeout_hit;
  logic                 done_accept;
  logic                 timeout_fire;
  meas_state_t          after_txn;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------

  // Exit condition is "sec_cnt + 1 == period", rewritten as a compare against
  // period - 1 so no extra adder is needed. A period of 0 behaves as 1.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    period_last = '0;
    if (period_q != '0) begin
      period_last = CNT_W'(period_q - PERIOD_W'(1));
    end
  end

  assign period_hit   = (sec_cnt == period_last);
  assign timeout_hit  = (sec_cnt == TIMEOUT_LAST);

  // sensor_done is only meaningful while waiting for it; a strobe coinciding
  // with the timeout tick counts as a success.
  assign done_accept  = (state == ST_WAIT_DONE) && sensor_done;
  assign timeout_fire = (state == ST_WAIT_DONE) && !sensor_done &&
                        count_eq_1s && timeout_hit;

  // Where a finished transaction goes: dropping ctrl_en mid-transaction lets
  // the transaction complete and then parks the controller.
  assign after_txn    = ctrl_en ? ST_WAIT_PERIOD : ST_IDLE;

  // ---------------------------------------------------------------------------
  // Output decode: timer control, trigger and busy follow the state, with the
  // timer cleared on every tick so each second restarts from zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    temp_counter_en  = 1'b0;
    temp_counter_clr = 1'b0;
    meas_start       = 1'b0;
    busy             = 1'b1;
    unique case (state)
      ST_IDLE: begin
        temp_counter_clr = 1'b1;
        busy             = 1'b0;
      end
      ST_WAIT_PERIOD: begin
        temp_counter_en  = 1'b1;
        temp_counter_clr = count_eq_1s;
      end
      ST_TRIGGER: begin
        meas_start       = 1'b1;
        temp_counter_clr = 1'b1;
      end
      ST_WAIT_DONE: begin
        temp_counter_en  = 1'b1;
        // A completed transaction restarts the period from a clean second.
        temp_counter_clr = count_eq_1s | sensor_done;
      end
      default: begin
        temp_counter_clr = 1'b1;
        busy             = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State machine, seconds counter, capture registers and status flags
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state       <= ST_IDLE;
      sec_cnt     <= '0;
      period_q    <= '0;
      temp_data   <= '0;
      hum_data    <= '0;
      data_valid  <= 1'b0;
      timeout_err <= 1'b0;
      meas_cnt    <= '0;
    end else begin
      data_valid <= 1'b0;

      // Setting wins over a coincident clear.
      if (timeout_fire) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end

      unique case (state)
        ST_IDLE: begin
          if (ctrl_en) begin
            state    <= ST_WAIT_PERIOD;
            period_q <= period_sec;
            sec_cnt  <= '0;
          end
        end

        ST_WAIT_PERIOD: begin
          if (!ctrl_en) begin
            state   <= ST_IDLE;
            sec_cnt <= '0;
          end else if (count_eq_1s) begin
            if (period_hit) begin
              state   <= ST_TRIGGER;
              sec_cnt <= '0;
            end else begin
              sec_cnt <= sec_cnt + CNT_W'(1);
            end
          end
        end

        ST_TRIGGER: begin
          state   <= ST_WAIT_DONE;
          sec_cnt <= '0;
        end

        ST_WAIT_DONE: begin
          if (done_accept) begin
            temp_data  <= sensor_temp;
            hum_data   <= sensor_hum;
            meas_cnt   <= meas_cnt + 16'd1;
            data_valid <= 1'b1;
            period_q   <= period_sec;
            sec_cnt    <= '0;
            state      <= after_txn;
          end else if (count_eq_1s) begin
            if (timeout_hit) begin
              period_q <= period_sec;
              sec_cnt  <= '0;
              state    <= after_txn;
            end else begin
              sec_cnt  <= sec_cnt + CNT_W'(1);
            end
          end
        end

        default: begin
          state   <= ST_IDLE;
          sec_cnt <= '0;
        end
      endcase
    end
  end

endmodule : temp_hum_meas_ctrl

// File: doc/temp_hum_meas_ctrl.md
TEMP_HUM_MEAS_CTRL -- requirements
Module: temp_hum_meas_ctrl

Interface
REQ-001 Parameter PERIOD_W, default 8, width of the measurement-period field in seconds.
REQ-002 Parameter DATA_W, default 16, width of each temperature/humidity sample.
REQ-003 Parameter TIMEOUT_SEC, default 2, whole seconds allowed for the sensor to answer a trigger.
REQ-004 pclk  in  1  single clock; all state changes on the rising edge.
REQ-005 preset  in  1  reset; synchronous and active-high.
REQ-006 ctrl_en  in  1  level; 1 enables periodic measurement.
REQ-007 period_sec  in  PERIOD_W  seconds between triggers; sampled on leaving IDLE and after each completed transaction.
REQ-008 count_eq_1s  in  1  one-cycle tick from the 1 s timer counter.
REQ-009 temp_counter_en  out  1  enable for the 1 s timer counter.
REQ-010 temp_counter_clr  out  1  synchronous clear for the 1 s timer counter.
REQ-011 meas_start  out  1  one-cycle trigger pulse to the sensor interface.
REQ-012 sensor_done  in  1  one-cycle completion strobe; sensor_temp/sensor_hum are valid in the same cycle.
REQ-013 sensor_temp, sensor_hum  in  DATA_W each  raw samples.
REQ-014 temp_data, hum_data  out  DATA_W each  last captured samples.
REQ-015 data_valid  out  1  one-cycle pulse on the cycle after capture.
REQ-016 timeout_err  out  1  sticky timeout flag.
REQ-017 err_clr  in  1  one-cycle clear for timeout_err.
REQ-018 busy  out  1  1 in every state except IDLE.
REQ-019 meas_cnt  out  16  count of successful captures.

Function
REQ-020 FSM states: IDLE, WAIT_PERIOD, TRIGGER, WAIT_DONE; temp_counter_en, temp_counter_clr, meas_start and busy are Moore decodes of state plus count_eq_1s.
REQ-021 IDLE: temp_counter_clr=1, temp_counter_en=0; ctrl_en=1 -> WAIT_PERIOD, latch period_sec, sec_cnt=0.
REQ-022 WAIT_PERIOD: temp_counter_en=1; on count_eq_1s, temp_counter_clr=1 in that cycle and sec_cnt increments.
REQ-023 WAIT_PERIOD exits to TRIGGER on the tick where sec_cnt+1 equals the latched period; a latched period of 0 is treated as 1.
REQ-024 TRIGGER: lasts exactly one cycle; meas_start=1, temp_counter_clr=1, sec_cnt cleared -> WAIT_DONE.
REQ-025 WAIT_DONE: temp_counter_en=1; seconds are counted as in WAIT_PERIOD.
REQ-026 sensor_done in WAIT_DONE: capture sensor_temp/sensor_hum, meas_cnt+1 (wraps 0xFFFF->0), data_valid=1 on the next cycle, re-latch period_sec -> WAIT_PERIOD with sec_cnt=0 and timer cleared.
REQ-027 Timeout: when the TIMEOUT_SEC-th tick arrives in WAIT_DONE without sensor_done, set timeout_err, capture nothing -> WAIT_PERIOD.
REQ-028 sensor_done and the timeout tick in the same cycle: sensor_done wins, no error.
REQ-029 sensor_done outside WAIT_DONE is ignored.
REQ-030 ctrl_en=0 in WAIT_PERIOD -> IDLE next cycle; in TRIGGER or WAIT_DONE, the transaction finishes (done or timeout) and then -> IDLE instead of WAIT_PERIOD.
REQ-031 timeout_err is cleared by err_clr; a set and a clear in the same cycle leave the flag set.
REQ-032 period_sec changes take effect only at a latch point (REQ-021, REQ-026, REQ-027).

Reset
REQ-033 preset=1 forces IDLE, sec_cnt=0, meas_cnt=0, temp_data=0, hum_data=0, data_valid=0, timeout_err=0, meas_start=0, temp_counter_en=0, temp_counter_clr=1, busy=0, from any state including mid-transaction.

Structure
REQ-034 The state enum and the defaults TIMEOUT_SEC and PERIOD_W shall be placed in shared package temp_hum_pkg.
REQ-035 The 1 s timer counter (temp_timer_counter) shall remain external; the controller shall not instantiate sub-modules.

Verification
REQ-036 ctrl_en=1, period_sec=3, sensor_done 5 cycles after meas_start -> meas_start on the 3rd tick, data captured, data_valid one cycle later, meas_cnt=1.
REQ-037 No sensor_done after trigger -> timeout_err=1 on the 2nd tick, data unchanged, next trigger after 3 further ticks.
REQ-038 sensor_done and the 2nd tick in the same cycle -> capture occurs, timeout_err stays 0.
REQ-039 ctrl_en dropped in WAIT_DONE, done 10 cycles later -> capture occurs, then IDLE, busy=0, temp_counter_clr=1.
REQ-040 period_sec=0 -> trigger on every tick; preset mid-WAIT_DONE -> all REQ-033 values on the next edge.
REQ-041 timeout_err=1 with err_clr pulsed -> 0 next cycle; err_clr coincident with a new timeout -> stays 1.
